bcd_addmach_ctrl: RTL and testbench
===================================

# bcd_addmach_ctrl

Sequencing controller for a four-digit BCD adding machine. Keypad digits shift into an entry register. An add command then runs a digit-serial addition of the entry register into an accumulator. The addition reuses a single one-digit BCD adder (`bcdadd1`) over four consecutive cycles instead of a parallel 16-bit adder. The block sits between the debounced/edge-detected push-button logic and the seven-segment decoders (`ssdec`) in `top`.

## Interface
Parameters: none.

Ports:
- `hz100` in 1: system clock. One clock domain.
- `reset` in 1: asynchronous, active-low reset.
- `digit_in` in 4: BCD digit value. Sampled only when `digit_strobe`=1.
- `digit_strobe` in 1: one-cycle pulse requesting digit entry.
- `add_strobe` in 1: one-cycle pulse requesting acc ← acc + entry.
- `clr_strobe` in 1: one-cycle pulse requesting a full clear.
- `display` out 16: four BCD digits to show. Equals acc when `show_acc`=1, else entry.
- `show_acc` out 1: 1 when `display` is the accumulator.
- `busy` out 1: 1 while in state ADD.
- `overflow` out 1: sticky; set when a sum exceeds 9999.

All strobes are synchronous to `hz100`, already edge-detected, and high for exactly one cycle.

## Operation
Registers:
- `entry[15:0]`, `acc[15:0]`
- `idx[1:0]`, `carry`
- `show_acc`, `overflow`
- `state` ∈ {ENTRY, ADD}

Reset (`reset`=0, asynchronous):
- state=ENTRY
- entry=0, acc=0
- idx=0, carry=0
- show_acc=0, overflow=0
- Outputs therefore read display=16'h0000, busy=0, overflow=0, show_acc=0.

State ENTRY. Strobe priority is clr > add > digit; only the winner acts.
- `clr_strobe`: entry=0, acc=0, overflow=0, show_acc=0.
- `add_strobe`: state←ADD, idx←0, carry←0.
- `digit_strobe` with digit_in ≤ 9: entry←{entry[11:0], digit_in}, which drops the top digit; show_acc←0.
- `digit_strobe` with digit_in > 9: ignored, no register changes.

State ADD, one digit per cycle:
- Computes bcdadd1(a=acc[4·idx+3:4·idx], b=entry[4·idx+3:4·idx], ci=carry).
- Writes the sum back to acc digit idx and sets carry←co.
- idx<3: idx←idx+1, stay in ADD.
- idx=3:
  - state←ENTRY
  - overflow←overflow | co
  - entry←0
  - show_acc←1
  - idx←0, carry←0

Strobes during ADD:
- `add_strobe` and `digit_strobe` are ignored and not queued.
- `clr_strobe` aborts. On the next edge: state=ENTRY, entry=acc=0, overflow=0, show_acc=0, idx=0, carry=0. Partially written acc digits are discarded.

Arithmetic and width rules:
- acc wraps modulo 10000 decimal.
- Only digits 0–9 are ever stored, so bcdadd1 never sees an invalid BCD operand.
- bcdadd1 is the only adder. No binary + is applied to the 16-bit values.

## Timing
- `add_strobe` is sampled at edge k, and state=ADD after edge k.
- Digits 0..3 of acc are written at edges k+1..k+4.
- `busy`=1 from edge k to edge k+4, which is 4 cycles. The result is on `display` with show_acc=1 after edge k+4.
- A digit entry is visible on `display` one edge after its strobe.
- Clear takes effect one edge after its strobe, in either state.
- All outputs are registered or a direct mux of registers; there is no combinational path from strobes to outputs.
- Reset asserted mid-ADD forces all reset values immediately, without waiting for a clock. On release, the first strobe is honoured at the next edge.

## Test plan
1. Digits 1,2,3,4, add; digits 5,6,7,8, add.
   - display=0x6912, show_acc=1, overflow=0.
   - busy high for exactly 4 cycles per add.
2. Enter 9999, add; enter 0001, add.
   - acc=0x0000, overflow=1.
   - A further entry of 0005 then add gives 0x0005 with overflow still 1.
   - clr then gives overflow=0 and display=0x0000.
3. Enter digits 1,2,3,4,5.
   - display=0x2345.
   - digit_in=0xA with strobe leaves display=0x2345.
   - A digit after an add shows entry (show_acc=0).
4. add_strobe and digit_strobe pulsed during ADD cycles 2 and 3.
   - Result is identical to the unperturbed add.
   - busy stays 4 cycles; no second add starts.
5. clr_strobe in ADD cycle 2 of 5555+5555.
   - Next edge: display=0x0000, busy=0, overflow=0.
   - A subsequent 0001 add gives 0x0001.
6. Simultaneous clr+add+digit in ENTRY → clear only. Reset low mid-ADD → all outputs zero immediately, before the next clock edge.

Source files
------------

// File: rtl/bcd_addmach_ctrl.sv
// Sequencing controller for a four-digit BCD adding machine.
// Keypad digits shift into an entry register. An add command then folds the
// entry into the accumulator one digit per cycle, using a single one-digit
// BCD adder over four consecutive cycles.

// One-digit BCD adder: a + b + ci, with decimal correction.
// The operands are always valid BCD digits (0-9).
module bcdadd1 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] raw;

  // Add in binary, then apply the +6 decimal correction when the sum exceeds 9.
  always_comb begin
    raw = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
    if (raw > 5'd9) begin
      co = 1'b1;
      s  = raw[3:0] + 4'd6;
    end else begin
      co = 1'b0;
      s  = raw[3:0];
    end
  end
endmodule

module bcd_addmach_ctrl (
  input  logic        hz100,
  input  logic        reset,
  input  logic [3:0]  digit_in,
  input  logic        digit_strobe,
  input  logic        add_strobe,
  input  logic        clr_strobe,
  output logic [15:0] display,
  output logic        show_acc,
  output logic        busy,
  output logic        overflow
);
  typedef enum logic {ST_ENTRY, ST_ADD} state_t;

  state_t      state_reg;
  logic [15:0] entry_reg;
  logic [15:0] acc_reg;
  logic [1:0]  idx_reg;
  logic        carry_reg;
  logic        show_acc_reg;
  logic        overflow_reg;

  // Per-digit views of the operands and the accumulator with the current
  // digit replaced by the adder result.
  logic [3:0]  acc_dig   [4];
  logic [3:0]  entry_dig [4];
  logic [15:0] acc_next;
  logic [3:0]  sum_dig;
  logic        sum_co;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      assign acc_dig[gi]          = acc_reg[4*gi +: 4];
      assign entry_dig[gi]        = entry_reg[4*gi +: 4];
      assign acc_next[4*gi +: 4]  = (idx_reg == 2'(gi)) ? sum_dig : acc_reg[4*gi +: 4];
    end
  endgenerate

  // The only adder in the block: it processes the digit selected by idx_reg.
  bcdadd1 u_add (
    .a  (acc_dig[idx_reg]),
    .b  (entry_dig[idx_reg]),
    .ci (carry_reg),
    .s  (sum_dig),
    .co (sum_co)
  );

  // Controller state machine: keypad entry, clear, and the digit-serial add.
  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_ENTRY;
      entry_reg    <= 16'h0000;
      acc_reg      <= 16'h0000;
      idx_reg      <= 2'd0;
      carry_reg    <= 1'b0;
      show_acc_reg <= 1'b0;
      overflow_reg <= 1'b0;
    end else if (clr_strobe) begin
      // Clear wins in either state; an add in progress is abandoned.
      state_reg    <= ST_ENTRY;
      entry_reg    <= 16'h0000;
      acc_reg      <= 16'h0000;
      idx_reg      <= 2'd0;
      carry_reg    <= 1'b0;
      show_acc_reg <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_ENTRY: begin
          if (add_strobe) begin
            state_reg <= ST_ADD;
            idx_reg   <= 2'd0;
            carry_reg <= 1'b0;
          end else if (digit_strobe && (digit_in <= 4'd9)) begin
            entry_reg    <= {entry_reg[11:0], digit_in};
            show_acc_reg <= 1'b0;
          end
        end
        ST_ADD: begin
          // Strobes other than clear are ignored here and not queued.
          acc_reg   <= acc_next;
          carry_reg <= sum_co;
          if (idx_reg == 2'd3) begin
            state_reg    <= ST_ENTRY;
            overflow_reg <= overflow_reg | sum_co;
            entry_reg    <= 16'h0000;
            show_acc_reg <= 1'b1;
            idx_reg      <= 2'd0;
            carry_reg    <= 1'b0;
          end else begin
            idx_reg <= idx_reg + 2'd1;
          end
        end
        default: state_reg <= ST_ENTRY;
      endcase
    end
  end

  // Outputs are registers or a plain mux of registers.
  assign display  = show_acc_reg ? acc_reg : entry_reg;
  assign show_acc = show_acc_reg;
  assign busy     = (state_reg == ST_ADD);
  assign overflow = overflow_reg;
endmodule

// File: tb/tb_bcd_addmach_ctrl.sv
// Testbench for bcd_addmach_ctrl: directed scenarios plus a random walk,
// all checked against a decimal-arithmetic model of the adding machine.
module tb_bcd_addmach_ctrl;
  logic        hz100;
  logic        reset;
  logic [3:0]  digit_in;
  logic        digit_strobe;
  logic        add_strobe;
  logic        clr_strobe;
  logic [15:0] display;
  logic        show_acc;
  logic        busy;
  logic        overflow;

  int vectors;
  int miscompares;

  // Reference model state, held as plain decimal integers.
  int m_entry;
  int m_acc;
  bit m_show;
  bit m_ovf;

  bcd_addmach_ctrl dut (
    .hz100        (hz100),
    .reset        (reset),
    .digit_in     (digit_in),
    .digit_strobe (digit_strobe),
    .add_strobe   (add_strobe),
    .clr_strobe   (clr_strobe),
    .display      (display),
    .show_acc     (show_acc),
    .busy         (busy),
    .overflow     (overflow)
  );

  initial hz100 = 1'b0;
  always #5 hz100 = ~hz100;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    r[3:0]   = 4'(n % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[11:8]  = 4'((n / 100) % 10);
    r[15:12] = 4'((n / 1000) % 10);
    return r;
  endfunction

  function automatic logic [15:0] exp_display();
    return to_bcd(m_show ? m_acc : m_entry);
  endfunction

  task automatic model_clr();
    m_entry = 0; m_acc = 0; m_show = 0; m_ovf = 0;
  endtask

  task automatic model_digit(input int d);
    if (d <= 9) begin
      m_entry = (m_entry * 10 + d) % 10000;
      m_show  = 0;
    end
  endtask

  task automatic model_add();
    int s;
    s = m_acc + m_entry;
    if (s > 9999) m_ovf = 1;
    m_acc   = s % 10000;
    m_entry = 0;
    m_show  = 1;
  endtask

  // One-cycle strobe pulse; returns at the falling edge after the sampling edge.
  task automatic pulse(input logic c, input logic a, input logic d, input logic [3:0] v);
    @(negedge hz100);
    clr_strobe = c; add_strobe = a; digit_strobe = d; digit_in = v;
    @(negedge hz100);
    clr_strobe = 0; add_strobe = 0; digit_strobe = 0;
  endtask

  task automatic press_digit(input int d);
    pulse(1'b0, 1'b0, 1'b1, 4'(d));
    model_digit(d);
  endtask

  task automatic press_clr();
    pulse(1'b1, 1'b0, 1'b0, 4'd0);
    model_clr();
  endtask

  task automatic enter_number(input int n);
    press_digit((n / 1000) % 10);
    press_digit((n / 100) % 10);
    press_digit((n / 10) % 10);
    press_digit(n % 10);
  endtask

  // Issue an add and count busy cycles. While the busy count lies in [lo,hi]
  // the given extra strobes are driven. Bounded to 12 cycles.
  task automatic run_add(input int lo, input int hi, input logic c, input logic a,
                         input logic d, output int nb);
    nb = 0;
    @(negedge hz100);
    add_strobe = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge hz100);
      clr_strobe = 0; add_strobe = 0; digit_strobe = 0;
      if (busy !== 1'b1) break;
      nb++;
      if (nb >= lo && nb <= hi) begin
        clr_strobe = c; add_strobe = a; digit_strobe = d; digit_in = 4'd7;
      end
    end
    clr_strobe = 0; add_strobe = 0; digit_strobe = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    repeat (2) @(negedge hz100);
    vectors++; if (display !== 16'h0000) begin miscompares++; $display("FAIL reset_display: got %h want 0000", display); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (show_acc !== 1'b0) begin miscompares++; $display("FAIL reset_show_acc: got %b want 0", show_acc); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    reset = 1;
    model_clr();
  endtask

  task automatic test_basic_add();
    int nb;
    enter_number(1234);
    run_add(0, 0, 1'b0, 1'b0, 1'b0, nb);
    model_add();
    vectors++; if (nb != 4) begin miscompares++; $display("FAIL basic_busy1: got %0d cycles want 4", nb); end
    vectors++; if (display !== 16'h1234) begin miscompares++; $display("FAIL basic_sum1: got %h want 1234", display); end
    enter_number(5678);
    run_add(0, 0, 1'b0, 1'b0, 1'b0, nb);
    model_add();
    vectors++; if (nb != 4) begin miscompares++; $display("FAIL basic_busy2: got %0d cycles want 4", nb); end
    vectors++; if (display !== 16'h6912) begin miscompares++; $display("FAIL basic_sum2: got %h want 6912", display); end
    vectors++; if (show_acc !== 1'b1) begin miscompares++; $display("FAIL basic_show: got %b want 1", show_acc); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL basic_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_overflow();
    int nb;
    press_clr();
    enter_number(9999);
    run_add(0, 0, 1'b0, 1'b0, 1'b0, nb); model_add();
    enter_number(1);
    run_add(0, 0, 1'b0, 1'b0, 1'b0, nb); model_add();
    vectors++; if (display !== 16'h0000) begin miscompares++; $display("FAIL ovf_wrap: got %h want 0000", display); end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set: got %b want 1", overflow); end
    enter_number(5);
    run_add(0, 0, 1'b0, 1'b0, 1'b0, nb); model_add();
    vectors++; if (display !== 16'h0005) begin miscompares++; $display("FAIL ovf_next: got %h want 0005", display); end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    press_clr();
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clr: got %b want 0", overflow); end
    vectors++; if (display !== 16'h0000) begin miscompares++; $display("FAIL ovf_clr_disp: got %h want 0000", display); end
  endtask

  task automatic test_entry_shift();
    int nb;
    press_clr();
    for (int d = 1; d <= 5; d++) press_digit(d);
    vectors++; if (display !== 16'h2345) begin miscompares++; $display("FAIL shift_drop: got %h want 2345", display); end
    press_digit(10);
    vectors++; if (display !== 16'h2345) begin miscompares++; $display("FAIL shift_invalid: got %h want 2345", display); end
    run_add(0, 0, 1'b0, 1'b0, 1'b0, nb); model_add();
    vectors++; if (display !== exp_display()) begin miscompares++; $display("FAIL shift_add: got %h want %h", display, exp_display()); end
    press_digit(7);
    vectors++; if (show_acc !== 1'b0) begin miscompares++; $display("FAIL shift_show: got %b want 0", show_acc); end
    vectors++; if (display !== 16'h0007) begin miscompares++; $display("FAIL shift_after_add: got %h want 0007", display); end
  endtask

  task automatic test_strobes_during_add();
    int nb;
    press_clr();
    enter_number(1234);
    run_add(0, 0, 1'b0, 1'b0, 1'b0, nb); model_add();
    enter_number(4321);
    run_add(2, 3, 1'b0, 1'b1, 1'b1, nb); model_add();
    vectors++; if (nb != 4) begin miscompares++; $display("FAIL perturb_busy: got %0d cycles want 4", nb); end
    vectors++; if (display !== 16'h5555) begin miscompares++; $display("FAIL perturb_sum: got %h want 5555", display); end
    @(negedge hz100);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL perturb_no_readd: busy got %b want 0", busy); end
    vectors++; if (display !== exp_display()) begin miscompares++; $display("FAIL perturb_hold: got %h want %h", display, exp_display()); end
  endtask

  task automatic test_clear_abort();
    int nb;
    press_clr();
    enter_number(5555);
    run_add(0, 0, 1'b0, 1'b0, 1'b0, nb); model_add();
    enter_number(5555);
    run_add(2, 2, 1'b1, 1'b0, 1'b0, nb); model_clr();
    vectors++; if (nb != 2) begin miscompares++; $display("FAIL abort_busy: got %0d cycles want 2", nb); end
    vectors++; if (display !== 16'h0000) begin miscompares++; $display("FAIL abort_disp: got %h want 0000", display); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_idle: busy got %b want 0", busy); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL abort_ovf: got %b want 0", overflow); end
    enter_number(1);
    run_add(0, 0, 1'b0, 1'b0, 1'b0, nb); model_add();
    vectors++; if (display !== 16'h0001) begin miscompares++; $display("FAIL abort_next: got %h want 0001", display); end
  endtask

  task automatic test_simultaneous();
    press_clr();
    enter_number(42);
    pulse(1'b1, 1'b1, 1'b1, 4'd3);
    model_clr();
    vectors++; if (display !== 16'h0000) begin miscompares++; $display("FAIL simul_disp: got %h want 0000", display); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL simul_busy: got %b want 0", busy); end
    @(negedge hz100);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL simul_busy_later: got %b want 0", busy); end
  endtask

  task automatic test_async_reset();
    int nb;
    press_clr();
    enter_number(9999);
    run_add(0, 0, 1'b0, 1'b0, 1'b0, nb); model_add();
    enter_number(2);
    run_add(0, 0, 1'b0, 1'b0, 1'b0, nb); model_add();
    enter_number(2222);
    @(negedge hz100); add_strobe = 1;
    @(negedge hz100); add_strobe = 0;
    @(negedge hz100);
    #2 reset = 0;
    #1;
    vectors++; if (display !== 16'h0000) begin miscompares++; $display("FAIL areset_disp: got %h want 0000", display); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL areset_busy: got %b want 0", busy); end
    vectors++; if (show_acc !== 1'b0) begin miscompares++; $display("FAIL areset_show: got %b want 0", show_acc); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL areset_ovf: got %b want 0", overflow); end
    @(negedge hz100);
    reset = 1;
    model_clr();
    press_digit(5);
    vectors++; if (display !== 16'h0005) begin miscompares++; $display("FAIL areset_release: got %h want 0005", display); end
  endtask

  task automatic test_random();
    int r, d, nb;
    press_clr();
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 11);
      nb = 4;
      if (r == 0) begin
        press_clr();
      end else if (r <= 3) begin
        run_add(0, 0, 1'b0, 1'b0, 1'b0, nb);
        model_add();
      end else begin
        d = $urandom_range(0, 15);
        press_digit(d);
      end
      vectors++; if (nb != 4) begin miscompares++; $display("FAIL rand_busy[%0d]: got %0d cycles want 4", i, nb); end
      vectors++; if (display !== exp_display()) begin miscompares++; $display("FAIL rand_disp[%0d]: got %h want %h", i, display, exp_display()); end
      vectors++; if (show_acc !== m_show) begin miscompares++; $display("FAIL rand_show[%0d]: got %b want %b", i, show_acc, m_show); end
      vectors++; if (overflow !== m_ovf) begin miscompares++; $display("FAIL rand_ovf[%0d]: got %b want %b", i, overflow, m_ovf); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rand_idle[%0d]: busy got %b want 0", i, busy); end
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 0; digit_in = 0; digit_strobe = 0; add_strobe = 0; clr_strobe = 0;
    test_reset();
    test_basic_add();
    test_overflow();
    test_entry_shift();
    test_strobes_during_add();
    test_clear_abort();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
